// File: rtl/fuzz_equiv_pkg.sv
// Shared types and helpers for the fuzz equivalence monitor.
//   state_t      : monitor FSM states
//   DEFAULT_POLY : default MISR feedback polynomial
//   fold()       : XOR of the misr_w-bit slices of a bus; the top slice is zero-padded
package fuzz_equiv_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [31:0] DEFAULT_POLY = 32'h04C11DB7;

  // Upper bounds for fold(): buses up to 512 bits, signatures up to 64 bits.
  localparam int unsigned FOLD_MAX_IN  = 512;
  localparam int unsigned FOLD_MAX_OUT = 64;

  // Bit i of y lands in bit (i mod misr_w), which is the same as XORing the slices.
  function automatic logic [FOLD_MAX_OUT-1:0] fold(input logic [FOLD_MAX_IN-1:0] y,
                                                   input int unsigned width,
                                                   input int unsigned misr_w);
    logic [FOLD_MAX_OUT-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < FOLD_MAX_IN; i++) begin
      if (i < width) r[6'(i % misr_w)] = r[6'(i % misr_w)] ^ y[9'(i)];
    end
    return r;
  endfunction

endpackage

// File: rtl/fuzz_misr.sv
// Multiple-input signature register compacting one WIDTH-bit bus per enabled cycle.
//   clk, rst : clock, async active-high reset (sig <= SEED)
//   clear    : synchronous reload of SEED (has priority over en)
//   en       : fold din into the signature this cycle
//   din      : bus being compacted
//   sig      : current signature
module fuzz_misr
  import fuzz_equiv_pkg::*;
#(
  parameter int unsigned       WIDTH  = 386,
  parameter int unsigned       MISR_W = 32,
  parameter logic [MISR_W-1:0] POLY   = MISR_W'(DEFAULT_POLY),
  parameter logic [MISR_W-1:0] SEED   = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              en,
  input  logic [WIDTH-1:0]  din,
  output logic [MISR_W-1:0] sig
);

  logic [MISR_W-1:0] fold_c;

  always_comb fold_c = MISR_W'(fold(FOLD_MAX_IN'(din), WIDTH, MISR_W));

  // Galois-style shift with polynomial feedback from the MSB, then inject the folded sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        sig <= SEED;
    else if (clear) sig <= SEED;
    else if (en)    sig <= (sig << 1) ^ (sig[MISR_W-1] ? POLY : '0) ^ fold_c;
  end

endmodule

// File: rtl/fuzz_equiv_monitor.sv
// Run-time equivalence monitor: compacts y_a / y_b into MISR signatures over a
// programmed run and counts exact per-cycle mismatches.
//   clk, rst      : clock, async active-high reset
//   start,run_len : run request and its sample count (run_len==0 goes straight to DONE)
//   y_a, y_b      : reference and synthesised outputs
//   busy, done    : state flags (RUN / DONE)
//   mismatch      : some sample differed in the current/last run
//   first_bad     : 0-based index of the first differing sample
//   mis_count     : number of differing samples, saturating
//   sig_a, sig_b  : signatures of y_a and y_b
module fuzz_equiv_monitor
  import fuzz_equiv_pkg::*;
#(
  parameter int unsigned       WIDTH  = 386,
  parameter int unsigned       CNT_W  = 16,
  parameter int unsigned       MISR_W = 32,
  parameter logic [MISR_W-1:0] POLY   = MISR_W'(DEFAULT_POLY),
  parameter logic [MISR_W-1:0] SEED   = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CNT_W-1:0]  run_len,
  input  logic [WIDTH-1:0]  y_a,
  input  logic [WIDTH-1:0]  y_b,
  output logic              busy,
  output logic              done,
  output logic              mismatch,
  output logic [CNT_W-1:0]  first_bad,
  output logic [CNT_W-1:0]  mis_count,
  output logic [MISR_W-1:0] sig_a,
  output logic [MISR_W-1:0] sig_b
);

  state_t           state;
  logic [CNT_W-1:0] run_len_q;
  logic [CNT_W-1:0] idx;
  logic             accept_c;
  logic             sample_c;
  logic             neq_c;

  always_comb begin
    accept_c = start && (state != RUN);
    sample_c = (state == RUN);
    neq_c    = (y_a != y_b);
  end

  fuzz_misr #(.WIDTH(WIDTH), .MISR_W(MISR_W), .POLY(POLY), .SEED(SEED)) u_misr_a (
    .clk(clk), .rst(rst), .clear(accept_c), .en(sample_c), .din(y_a), .sig(sig_a)
  );

  fuzz_misr #(.WIDTH(WIDTH), .MISR_W(MISR_W), .POLY(POLY), .SEED(SEED)) u_misr_b (
    .clk(clk), .rst(rst), .clear(accept_c), .en(sample_c), .din(y_b), .sig(sig_b)
  );

  // Control FSM with counters; start is only honoured outside RUN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      mismatch  <= 1'b0;
      first_bad <= '0;
      mis_count <= '0;
      run_len_q <= '0;
      idx       <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            run_len_q <= run_len;
            idx       <= '0;
            mismatch  <= 1'b0;
            first_bad <= '0;
            mis_count <= '0;
            if (run_len != '0) begin
              state <= RUN;
              busy  <= 1'b1;
              done  <= 1'b0;
            end else begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
        RUN: begin
          if (neq_c) begin
            if (mis_count != '1) mis_count <= mis_count + CNT_W'(1);
            if (!mismatch) begin
              first_bad <= idx;
              mismatch  <= 1'b1;
            end
          end
          idx <= idx + CNT_W'(1);
          if (idx == run_len_q - CNT_W'(1)) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fuzz_equiv_monitor.sv
// Directed bench for fuzz_equiv_monitor: three instances (default, 32-bit, 4-bit counter).
module tb_fuzz_equiv_monitor;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- default-parameter instance ----------------
  logic         start, busy, done, mismatch;
  logic [15:0]  run_len, first_bad, mis_count;
  logic [385:0] y_a, y_b;
  logic [31:0]  sig_a, sig_b;

  fuzz_equiv_monitor u_dut (
    .clk(clk), .rst(rst), .start(start), .run_len(run_len), .y_a(y_a), .y_b(y_b),
    .busy(busy), .done(done), .mismatch(mismatch), .first_bad(first_bad),
    .mis_count(mis_count), .sig_a(sig_a), .sig_b(sig_b)
  );

  // ---------------- WIDTH=MISR_W=32 instance ----------------
  logic        s_start, s_busy, s_done, s_mismatch;
  logic [15:0] s_run_len, s_first_bad, s_mis_count;
  logic [31:0] s_ya, s_yb, s_sig_a, s_sig_b;

  fuzz_equiv_monitor #(.WIDTH(32), .MISR_W(32)) u_small (
    .clk(clk), .rst(rst), .start(s_start), .run_len(s_run_len), .y_a(s_ya), .y_b(s_yb),
    .busy(s_busy), .done(s_done), .mismatch(s_mismatch), .first_bad(s_first_bad),
    .mis_count(s_mis_count), .sig_a(s_sig_a), .sig_b(s_sig_b)
  );

  // ---------------- CNT_W=4 instance ----------------
  logic       c_start, c_busy, c_done, c_mismatch;
  logic [3:0] c_run_len, c_first_bad, c_mis_count;
  logic [7:0] c_ya, c_yb, c_sig_a, c_sig_b;

  fuzz_equiv_monitor #(.WIDTH(8), .CNT_W(4), .MISR_W(8), .POLY(8'h1D)) u_cnt4 (
    .clk(clk), .rst(rst), .start(c_start), .run_len(c_run_len), .y_a(c_ya), .y_b(c_yb),
    .busy(c_busy), .done(c_done), .mismatch(c_mismatch), .first_bad(c_first_bad),
    .mis_count(c_mis_count), .sig_a(c_sig_a), .sig_b(c_sig_b)
  );

  // Reference MISR step for the default configuration, written slice-wise.
  function automatic logic [31:0] misr_step(input logic [31:0] cur, input logic [385:0] y);
    logic [415:0] yy;
    logic [31:0]  f;
    yy = 416'(y);
    f  = '0;
    for (int s = 0; s < 13; s++) f ^= yy[32*s +: 32];
    return {cur[30:0], 1'b0} ^ (cur[31] ? 32'h04C11DB7 : 32'h0) ^ f;
  endfunction

  function automatic logic [385:0] rand_vec();
    logic [415:0] v;
    for (int w = 0; w < 13; w++) v[32*w +: 32] = $urandom;
    return v[385:0];
  endfunction

  logic [385:0] ya_v [8];
  logic [385:0] yb_v [8];
  logic [31:0]  exp_a, exp_b;

  initial begin
    rst = 1'b1;
    start = 0; run_len = '0; y_a = '0; y_b = '0;
    s_start = 0; s_run_len = '0; s_ya = '0; s_yb = '0;
    c_start = 0; c_run_len = '0; c_ya = '0; c_yb = '0;
    repeat (2) @(negedge clk);

    // Reset state
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_mismatch", 64'(mismatch), 64'd0);
    check("rst_first_bad", 64'(first_bad), 64'd0);
    check("rst_mis_count", 64'(mis_count), 64'd0);
    check("rst_sig_a", 64'(sig_a), 64'd0);
    check("rst_sig_b", 64'(sig_b), 64'd0);
    rst = 1'b0;

    // Small instance: run_len=2, both samples y=1 -> sig 1 then 3
    @(negedge clk); s_start = 1; s_run_len = 16'd2;
    @(negedge clk); s_start = 0; s_ya = 32'd1; s_yb = 32'd1;
    check("small_busy", 64'(s_busy), 64'd1);
    @(negedge clk);
    check("small_sig1", 64'(s_sig_a), 64'd1);
    check("small_done_early", 64'(s_done), 64'd0);
    @(negedge clk);
    check("small_sig_a", 64'(s_sig_a), 64'd3);
    check("small_sig_b", 64'(s_sig_b), 64'd3);
    check("small_done", 64'(s_done), 64'd1);
    check("small_busy_end", 64'(s_busy), 64'd0);
    check("small_mismatch", 64'(s_mismatch), 64'd0);
    check("small_mis_count", 64'(s_mis_count), 64'd0);

    // Default instance: 8 samples, differences at samples 2 (bit 385) and 5 (bit 0)
    exp_a = '0; exp_b = '0;
    for (int k = 0; k < 8; k++) begin
      ya_v[k] = rand_vec();
      yb_v[k] = ya_v[k];
    end
    yb_v[2][385] = ~yb_v[2][385];
    yb_v[5][0]   = ~yb_v[5][0];
    for (int k = 0; k < 8; k++) begin
      exp_a = misr_step(exp_a, ya_v[k]);
      exp_b = misr_step(exp_b, yb_v[k]);
    end
    @(negedge clk); start = 1; run_len = 16'd8;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk); start = 0; y_a = ya_v[k]; y_b = yb_v[k];
      if (k == 7) check("rand_busy_last", 64'(busy), 64'd1);
    end
    @(negedge clk);
    check("rand_done", 64'(done), 64'd1);
    check("rand_mismatch", 64'(mismatch), 64'd1);
    check("rand_first_bad", 64'(first_bad), 64'd2);
    check("rand_mis_count", 64'(mis_count), 64'd2);
    check("rand_sig_a", 64'(sig_a), 64'(exp_a));
    check("rand_sig_b", 64'(sig_b), 64'(exp_b));
    check("rand_sig_differ", 64'(sig_a != sig_b), 64'd1);
    @(negedge clk);
    check("rand_done_held", 64'(done), 64'd1);
    check("rand_first_bad_held", 64'(first_bad), 64'd2);

    // run_len=0 from DONE -> DONE next cycle with cleared results
    start = 1; run_len = 16'd0;
    @(negedge clk); start = 0;
    check("zero_done", 64'(done), 64'd1);
    check("zero_busy", 64'(busy), 64'd0);
    check("zero_sig_a", 64'(sig_a), 64'd0);
    check("zero_sig_b", 64'(sig_b), 64'd0);
    check("zero_mismatch", 64'(mismatch), 64'd0);
    check("zero_mis_count", 64'(mis_count), 64'd0);

    // CNT_W=4 instance: 15 differing samples
    c_start = 1; c_run_len = 4'd15;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk); c_start = 0; c_ya = 8'(k); c_yb = ~8'(k);
    end
    @(negedge clk);
    check("cnt4_done", 64'(c_done), 64'd1);
    check("cnt4_mis_count", 64'(c_mis_count), 64'd15);
    check("cnt4_first_bad", 64'(c_first_bad), 64'd0);
    check("cnt4_mismatch", 64'(c_mismatch), 64'd1);

    // Reset mid-run at sample 3 of run_len=10
    start = 1; run_len = 16'd10;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); start = 0; y_a = 386'd1; y_b = 386'd0;
    end
    @(negedge clk);
    check("abort_busy_pre", 64'(busy), 64'd1);
    rst = 1'b1;
    #1;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_mismatch", 64'(mismatch), 64'd0);
    check("abort_first_bad", 64'(first_bad), 64'd0);
    check("abort_mis_count", 64'(mis_count), 64'd0);
    check("abort_sig_a", 64'(sig_a), 64'd0);
    check("abort_sig_b", 64'(sig_b), 64'd0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    check("abort_idle_done", 64'(done), 64'd0);
    check("abort_idle_busy", 64'(busy), 64'd0);
    // Clean run_len=2 with y=5: sig 5 then 0xA^5=0xF
    start = 1; run_len = 16'd2;
    @(negedge clk); start = 0; y_a = 386'd5; y_b = 386'd5;
    @(negedge clk);
    @(negedge clk);
    check("post_done", 64'(done), 64'd1);
    check("post_mismatch", 64'(mismatch), 64'd0);
    check("post_sig_a", 64'(sig_a), 64'hF);
    check("post_sig_b", 64'(sig_b), 64'hF);

    // start re-pulsed during RUN is ignored
    start = 1; run_len = 16'd4;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      start = (k == 1);
      run_len = (k == 1) ? 16'd1 : 16'd4;
      y_a = 386'd7; y_b = 386'd7;
      if (k == 3) check("repulse_still_busy", 64'(busy), 64'd1);
    end
    start = 0;
    @(negedge clk);
    check("repulse_done", 64'(done), 64'd1);
    check("repulse_busy", 64'(busy), 64'd0);

    // start in DONE begins a new run with counters cleared
    start = 1; run_len = 16'd3;
    @(negedge clk); start = 0; y_a = 386'd1; y_b = 386'd2;
    check("restart_busy", 64'(busy), 64'd1);
    check("restart_done", 64'(done), 64'd0);
    check("restart_mis_count", 64'(mis_count), 64'd0);
    check("restart_mismatch", 64'(mismatch), 64'd0);
    repeat (3) @(negedge clk);
    check("restart_final_done", 64'(done), 64'd1);
    check("restart_final_count", 64'(mis_count), 64'd3);
    check("restart_final_first", 64'(first_bad), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
